// File: rtl/ps2_key_ctrl_pkg.sv
// Shared types and scan-code constants for the PS/2 key sequencing controller.
package ps2_key_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_DECODE = 2'd2
    } state_e;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // One decoded key event as presented on the output registers.
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [7:0] ascii;
    } key_evt_t;

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Receiver FIFO handshake: the receiver is the master, the key controller the slave.
interface ps2_key_ctrl_if;

    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_overflow;
    logic       kbd_nextdata_n;

    modport master (
        output kbd_data,
        output kbd_ready,
        output kbd_overflow,
        input  kbd_nextdata_n
    );

    modport slave (
        input  kbd_data,
        input  kbd_ready,
        input  kbd_overflow,
        output kbd_nextdata_n
    );

endinterface

// File: rtl/ps2_key_ctrl_ascii_lut.sv
// Set-2 scan code to ASCII lookup (module ps2_ascii_lut); only built when PS2_ASCII_EN is defined.
`ifdef PS2_ASCII_EN
module ps2_ascii_lut (
    input  logic [7:0] scan,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [7:0] lower;

    always_comb begin
        lower = 8'h00;
        case (scan)
            8'h1C: lower = 8'h61;
            8'h32: lower = 8'h62;
            8'h21: lower = 8'h63;
            8'h23: lower = 8'h64;
            8'h24: lower = 8'h65;
            8'h2B: lower = 8'h66;
            8'h34: lower = 8'h67;
            8'h33: lower = 8'h68;
            8'h43: lower = 8'h69;
            8'h3B: lower = 8'h6A;
            8'h42: lower = 8'h6B;
            8'h4B: lower = 8'h6C;
            8'h3A: lower = 8'h6D;
            8'h31: lower = 8'h6E;
            8'h44: lower = 8'h6F;
            8'h4D: lower = 8'h70;
            8'h15: lower = 8'h71;
            8'h2D: lower = 8'h72;
            8'h1B: lower = 8'h73;
            8'h2C: lower = 8'h74;
            8'h3C: lower = 8'h75;
            8'h2A: lower = 8'h76;
            8'h1D: lower = 8'h77;
            8'h22: lower = 8'h78;
            8'h35: lower = 8'h79;
            8'h1A: lower = 8'h7A;
            8'h45: lower = 8'h30;
            8'h16: lower = 8'h31;
            8'h1E: lower = 8'h32;
            8'h26: lower = 8'h33;
            8'h25: lower = 8'h34;
            8'h2E: lower = 8'h35;
            8'h36: lower = 8'h36;
            8'h3D: lower = 8'h37;
            8'h3E: lower = 8'h38;
            8'h46: lower = 8'h39;
            default: lower = 8'h00;
        endcase
        // Shift only affects letters; digits keep their unshifted glyph.
        ascii = lower;
        if (shift && lower >= 8'h61 && lower <= 8'h7A)
            ascii = lower - 8'h20;
    end

endmodule
`endif

// File: rtl/ps2_key_ctrl.sv
// Drains the PS/2 receiver FIFO, folds E0/F0 prefixes into key events and tracks held key,
// press count and overflow. ASCII translation is built only when PS2_ASCII_EN is defined.
module ps2_key_ctrl
    import ps2_key_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    ps2_key_ctrl_if.slave    kbd,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_release,
    output logic [7:0]       key_ascii,
    output logic             key_held,
    output logic [8:0]       held_code,
    output logic [CNT_W-1:0] press_count,
    output logic             err
);

    state_e           state_q, state_d;
    logic [7:0]       code_q, code_d;
    logic             ext_f_q, ext_f_d;
    logic             brk_f_q, brk_f_d;
    key_evt_t         evt_q, evt_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic [8:0]       held_code_q, held_code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [7:0]       ascii_w;
    logic [8:0]       key_id;
    logic             held_match;

    assign key_id     = {ext_f_q, code_q};
    assign held_match = held_q && (key_id == held_code_q);

`ifdef PS2_ASCII_EN
    logic       shift_q, shift_d;
    logic [7:0] lut_ascii;

    ps2_ascii_lut u_ascii_lut (
        .scan  (code_q),
        .shift (shift_q),
        .ascii (lut_ascii)
    );

    assign ascii_w = ext_f_q ? 8'h00 : lut_ascii;

    always_comb begin
        shift_d = shift_q;
        if (state_q == S_DECODE && (code_q == SC_LSHIFT || code_q == SC_RSHIFT))
            shift_d = !brk_f_q;
    end

    always_ff @(posedge clk) begin
        if (clrn) shift_q <= 1'b0;
        else      shift_q <= shift_d;
    end
`else
    assign ascii_w = 8'h00;
`endif

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        ext_f_d     = ext_f_q;
        brk_f_d     = brk_f_q;
        evt_d       = evt_q;
        valid_d     = 1'b0;
        held_d      = held_q;
        held_code_d = held_code_q;
        cnt_d       = cnt_q;
        err_d       = err_q | kbd.kbd_overflow;

        case (state_q)
            S_IDLE: begin
                if (kbd.kbd_ready) begin
                    code_d  = kbd.kbd_data;
                    state_d = S_POP;
                end
            end
            S_POP: state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_IDLE;
                if (code_q == SC_EXT) begin
                    ext_f_d = 1'b1;
                end else if (code_q == SC_BRK) begin
                    brk_f_d = 1'b1;
                end else begin
                    valid_d    = 1'b1;
                    evt_d.code  = code_q;
                    evt_d.ext   = ext_f_q;
                    evt_d.rel   = brk_f_q;
                    evt_d.ascii = ascii_w;
                    ext_f_d    = 1'b0;
                    brk_f_d    = 1'b0;
                    // A make of the already-held key is typematic repeat: event only.
                    if (!brk_f_q) begin
                        if (!held_match) begin
                            cnt_d       = cnt_q + CNT_W'(1);
                            held_code_d = key_id;
                            held_d      = 1'b1;
                        end
                    end else if (held_match) begin
                        held_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            state_q     <= S_IDLE;
            code_q      <= 8'h00;
            ext_f_q     <= 1'b0;
            brk_f_q     <= 1'b0;
            evt_q       <= '0;
            valid_q     <= 1'b0;
            held_q      <= 1'b0;
            held_code_q <= 9'h000;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            ext_f_q     <= ext_f_d;
            brk_f_q     <= brk_f_d;
            evt_q       <= evt_d;
            valid_q     <= valid_d;
            held_q      <= held_d;
            held_code_q <= held_code_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign kbd.kbd_nextdata_n = (state_q != S_POP);
    assign key_valid          = valid_q;
    assign key_code           = evt_q.code;
    assign key_ext            = evt_q.ext;
    assign key_release        = evt_q.rel;
    assign key_ascii          = evt_q.ascii;
    assign key_held           = held_q;
    assign held_code          = held_code_q;
    assign press_count        = cnt_q;
    assign err                = err_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: FIFO model feeding byte vectors, scoreboard of expected key events.
`timescale 1ns/1ps
module tb_ps2_key_ctrl;

    localparam int CNT_W = 8;
`ifdef PS2_ASCII_EN
    localparam bit ASC = 1'b1;
`else
    localparam bit ASC = 1'b0;
`endif

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [7:0] ascii;
        logic       held;
        logic [8:0] hcode;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        bit         evt;
        exp_t       e;
    } vec_t;

    logic             clk  = 1'b0;
    logic             clrn = 1'b1;
    logic             key_valid, key_ext, key_release, key_held, err;
    logic [7:0]       key_code, key_ascii;
    logic [8:0]       held_code;
    logic [CNT_W-1:0] press_count;

    ps2_key_ctrl_if kbd ();

    ps2_key_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .kbd         (kbd.slave),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_release (key_release),
        .key_ascii   (key_ascii),
        .key_held    (key_held),
        .held_code   (held_code),
        .press_count (press_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] fifo[$];
    exp_t       sb[$];
    int         pop_cyc[$];
    vec_t       tbl[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        kbd.kbd_ready = (fifo.size() != 0);
        kbd.kbd_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        refresh();
    endtask

    function automatic vec_t mk(input logic [7:0] b, input bit evt, input logic [7:0] code,
                                input logic ext, input logic rel, input logic [7:0] ascii,
                                input logic held, input logic [8:0] hcode, input logic [7:0] cnt);
        vec_t v;
        v.b = b;
        v.evt = evt;
        v.e.code = code;
        v.e.ext = ext;
        v.e.rel = rel;
        v.e.ascii = ASC ? ascii : 8'h00;
        v.e.held = held;
        v.e.hcode = hcode;
        v.e.cnt = cnt;
        return v;
    endfunction

    function automatic vec_t pfx(input logic [7:0] b);
        return mk(b, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 9'h000, 8'h00);
    endfunction

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && fifo.size() == 0) break;
            @(negedge clk);
        end
        chk({nm, "_events_left"}, 32'(sb.size()), 32'd0);
    endtask

    // Receiver FIFO model: pops the head on every cycle the pop strobe is low.
    initial begin
        logic prev_low;
        prev_low = 1'b0;
        kbd.kbd_overflow = 1'b0;
        refresh();
        forever begin
            @(negedge clk);
            if (kbd.kbd_nextdata_n === 1'b0) begin
                chk("pop_width", 32'(prev_low), 32'd0);
                if (fifo.size() == 0) begin
                    chk("pop_empty_fifo", 32'd1, 32'd0);
                end else begin
                    void'(fifo.pop_front());
                    pop_cyc.push_back(cyc);
                end
            end
            prev_low = (kbd.kbd_nextdata_n === 1'b0);
            refresh();
        end
    end

    // Event monitor against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 32'(key_code), 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("key_code",    32'(key_code),    32'(e.code));
                    chk("key_ext",     32'(key_ext),     32'(e.ext));
                    chk("key_release", 32'(key_release), 32'(e.rel));
                    chk("key_ascii",   32'(key_ascii),   32'(e.ascii));
                    chk("key_held",    32'(key_held),    32'(e.held));
                    chk("held_code",   32'(held_code),   32'(e.hcode));
                    chk("press_count", 32'(press_count), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, 9'h01C, 8'd1));
        tbl.push_back(pfx(8'hF0));
        tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 1, 8'h61, 0, 9'h01C, 8'd1));
        tbl.push_back(pfx(8'hE0));
        tbl.push_back(mk(8'h75, 1, 8'h75, 1, 0, 8'h00, 1, 9'h175, 8'd2));
        tbl.push_back(pfx(8'hE0));
        tbl.push_back(pfx(8'hF0));
        tbl.push_back(mk(8'h75, 1, 8'h75, 1, 1, 8'h00, 0, 9'h175, 8'd2));
        tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, 9'h01C, 8'd3));
        tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, 9'h01C, 8'd3));
        tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, 9'h01C, 8'd3));
        tbl.push_back(mk(8'h32, 1, 8'h32, 0, 0, 8'h62, 1, 9'h032, 8'd4));
        tbl.push_back(mk(8'h12, 1, 8'h12, 0, 0, 8'h00, 1, 9'h012, 8'd5));
        tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 8'h41, 1, 9'h01C, 8'd6));
        tbl.push_back(pfx(8'hF0));
        tbl.push_back(mk(8'h12, 1, 8'h12, 0, 1, 8'h00, 1, 9'h01C, 8'd6));
        tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, 9'h01C, 8'd6));
        tbl.push_back(pfx(8'hF0));
        tbl.push_back(pfx(8'hE0));
        tbl.push_back(mk(8'h1C, 1, 8'h1C, 1, 1, 8'h00, 1, 9'h01C, 8'd6));
        tbl.push_back(pfx(8'hE0));
        tbl.push_back(pfx(8'hE0));
        tbl.push_back(pfx(8'hF0));
        tbl.push_back(pfx(8'hF0));
        tbl.push_back(mk(8'h6B, 1, 8'h6B, 1, 1, 8'h00, 1, 9'h01C, 8'd6));
        tbl.push_back(mk(8'h05, 1, 8'h05, 0, 0, 8'h00, 1, 9'h005, 8'd7));

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_nextdata_n", 32'(kbd.kbd_nextdata_n), 32'd1);
        chk("rst_key_valid",  32'(key_valid),   32'd0);
        chk("rst_key_code",   32'(key_code),    32'd0);
        chk("rst_key_ext",    32'(key_ext),     32'd0);
        chk("rst_key_rel",    32'(key_release), 32'd0);
        chk("rst_key_ascii",  32'(key_ascii),   32'd0);
        chk("rst_key_held",   32'(key_held),    32'd0);
        chk("rst_held_code",  32'(held_code),   32'd0);
        chk("rst_press_cnt",  32'(press_count), 32'd0);
        chk("rst_err",        32'(err),         32'd0);
        clrn = 1'b0;
        @(negedge clk);

        // Whole table loaded back-to-back into the FIFO in one go
        foreach (tbl[i]) begin
            fifo.push_back(tbl[i].b);
            if (tbl[i].evt) sb.push_back(tbl[i].e);
        end
        refresh();
        @(negedge clk);
        chk("lat_pop_low",   32'(kbd.kbd_nextdata_n), 32'd0);
        chk("lat_no_event1", 32'(key_valid), 32'd0);
        @(negedge clk);
        chk("lat_pop_high",  32'(kbd.kbd_nextdata_n), 32'd1);
        chk("lat_no_event2", 32'(key_valid), 32'd0);
        @(negedge clk);
        chk("lat_event",     32'(key_valid), 32'd1);
        wait_drain("table");
        chk("pop_count", 32'(pop_cyc.size()), 32'(tbl.size()));
        bad = 1'b0;
        for (int i = 1; i < pop_cyc.size(); i++)
            if (pop_cyc[i] - pop_cyc[i-1] != 3) bad = 1'b1;
        chk("pop_cadence", 32'(bad), 32'd0);
        repeat (2) @(negedge clk);
        chk("idle_no_pop", 32'(kbd.kbd_nextdata_n), 32'd1);

        // Sticky overflow
        kbd.kbd_overflow = 1'b1;
        @(negedge clk);
        kbd.kbd_overflow = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);

        // Reset while the pop strobe is active: byte aborted, no event
        push(8'h1C);
        @(negedge clk);
        chk("mid_pop_strobe", 32'(kbd.kbd_nextdata_n), 32'd0);
        clrn = 1'b1;
        @(negedge clk);
        clrn = 1'b0;
        chk("mid_rst_valid",     32'(key_valid),   32'd0);
        chk("mid_rst_nextdata",  32'(kbd.kbd_nextdata_n), 32'd1);
        chk("mid_rst_err",       32'(err),         32'd0);
        chk("mid_rst_cnt",       32'(press_count), 32'd0);
        chk("mid_rst_held",      32'(key_held),    32'd0);
        chk("mid_rst_held_code", 32'(held_code),   32'd0);
        chk("mid_rst_key_code",  32'(key_code),    32'd0);
        repeat (4) @(negedge clk);

        // Reset clears a pending E0 prefix
        push(8'hE0);
        repeat (4) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        clrn = 1'b0;
        sb.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, 9'h01C, 8'd1).e);
        push(8'h1C);
        wait_drain("post_reset");
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
